// File: rtl/wavelet_pkg.sv
// Shared constants and types for the wavelet squash/unsquash datapath.
package wavelet_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned LIFT_SHIFT = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_EVEN = 2'd1,
      SEND_ODD  = 2'd2
   } pair_state_e;

endpackage

// File: rtl/wavelet_unsquash_if.sv
// Coefficient-in / pixel-out handshake bundle for the unsquash block.
interface wavelet_unsquash_if #(
   parameter int unsigned DATA_W = wavelet_pkg::DEF_DATA_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_l;
   logic [DATA_W-1:0] in_h;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_l, in_h, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_l, in_h, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/wavelet_unsquash_lift.sv
// Two-stage inverse lifting pipeline: S1 holds L, H, H>>shift; S2 holds even and H.
module wavelet_unsquash_lift
   import wavelet_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_l,
   input  logic [DATA_W-1:0] in_h,
   input  logic              take,
   output logic              in_ready_c,
   output logic              s2_valid,
   output logic [DATA_W-1:0] s2_even,
   output logic [DATA_W-1:0] s2_h
);

   logic              v1_q, v1_d, v2_q, v2_d;
   logic [DATA_W-1:0] l_q, l_d, h_q, h_d, hs_q, hs_d;
   logic [DATA_W-1:0] even_q, even_d, h2_q, h2_d;
   logic              s1_adv_c, accept_c;

   always_comb begin
      v1_d   = v1_q;
      l_d    = l_q;
      h_d    = h_q;
      hs_d   = hs_q;
      v2_d   = v2_q;
      even_d = even_q;
      h2_d   = h2_q;

      s1_adv_c   = v1_q && (!v2_q || take);
      in_ready_c = !rst && (!v1_q || s1_adv_c);
      accept_c   = in_valid && in_ready_c;

      if (accept_c) begin
         v1_d = 1'b1;
         l_d  = in_l;
         h_d  = in_h;
         hs_d = in_h >> LIFT_SHIFT;
      end else if (s1_adv_c) begin
         v1_d = 1'b0;
      end

      // even = L - (H >> shift); H passes through for the odd reconstruction
      if (s1_adv_c) begin
         v2_d   = 1'b1;
         even_d = l_q - hs_q;
         h2_d   = h_q;
      end else if (take) begin
         v2_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         l_q    <= '0;
         h_q    <= '0;
         hs_q   <= '0;
         v2_q   <= 1'b0;
         even_q <= '0;
         h2_q   <= '0;
      end else begin
         v1_q   <= v1_d;
         l_q    <= l_d;
         h_q    <= h_d;
         hs_q   <= hs_d;
         v2_q   <= v2_d;
         even_q <= even_d;
         h2_q   <= h2_d;
      end
   end

   assign s2_valid = v2_q;
   assign s2_even  = even_q;
   assign s2_h     = h2_q;

endmodule

// File: rtl/wavelet_unsquash.sv
// Inverse integer lifting: (L, H) coefficient pairs in, even/odd pixel stream out.
module wavelet_unsquash
   import wavelet_pkg::*;
#(
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned PAIRS_PER_LINE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   wavelet_unsquash_if.slave     bus
);

   localparam int unsigned CNT_W = (PAIRS_PER_LINE > 1) ? $clog2(PAIRS_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAIRS_PER_LINE - 1);

   pair_state_e       state_q, state_d;
   logic [DATA_W-1:0] odd_q, odd_d, data_q, data_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              s2_valid;
   logic [DATA_W-1:0] s2_even, s2_h;
   logic              in_ready_c, p_load_c;

   wavelet_unsquash_lift #(.DATA_W(DATA_W)) u_lift (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (bus.in_valid),
      .in_l       (bus.in_l),
      .in_h       (bus.in_h),
      .take       (p_load_c),
      .in_ready_c (in_ready_c),
      .s2_valid   (s2_valid),
      .s2_even    (s2_even),
      .s2_h       (s2_h)
   );

   // P reloads on the same edge the odd pixel leaves, keeping output gap-free
   assign p_load_c = s2_valid &&
                     ((state_q == IDLE) || ((state_q == SEND_ODD) && bus.out_ready));

   always_comb begin
      state_d = state_q;
      odd_d   = odd_q;
      data_d  = data_q;
      last_d  = last_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (p_load_c) state_d = SEND_EVEN;
         end
         SEND_EVEN: begin
            if (bus.out_ready) begin
               state_d = SEND_ODD;
               data_d  = odd_q;
               last_d  = (cnt_q == CNT_MAX);
            end
         end
         SEND_ODD: begin
            if (bus.out_ready) begin
               state_d = p_load_c ? SEND_EVEN : IDLE;
               last_d  = 1'b0;
               cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // odd = H + even, formed as the pair enters P
      if (p_load_c) begin
         data_d = s2_even;
         odd_d  = s2_h + s2_even;
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         odd_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         odd_q   <= odd_d;
         data_q  <= data_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state_q != IDLE);
   assign bus.out_data  = data_q;
   assign bus.out_last  = last_q;

endmodule
